// File: rtl/pixel_riscv_soc_pkg.sv
// Shared SoC types for the instruction bus: decoded slave IDs, decoder state and
// router defaults.
package pixel_riscv_soc_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    BOOT_ROM = 2'd1,
    CODE_RAM = 2'd2
  } instr_bus_slave_t;

  typedef struct packed {
    logic [31:0]      fetch_addr;
    instr_bus_slave_t requested_slave;
  } instr_bus_state_t;

  localparam int unsigned INSTR_BUS_MAX_OUTSTANDING = 2;
  localparam logic [31:0] INSTR_BUS_ERR_RDATA       = 32'h0000_0000;

  function automatic logic is_mapped(instr_bus_slave_t s);
    return (s == BOOT_ROM) || (s == CODE_RAM);
  endfunction

endpackage

// File: rtl/instr_bus_id_fifo.sv
// In-order FIFO of slave IDs for in-flight instruction fetches.
// Pushes while full and pops while empty are ignored.
module instr_bus_id_fifo
  import pixel_riscv_soc_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  instr_bus_slave_t push_id,
  input  logic             pop,
  output instr_bus_slave_t head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam ptr_t LastPtr = ptr_t'(Depth - 1);
  localparam cnt_t FullCnt = cnt_t'(Depth);

  instr_bus_slave_t mem_q [Depth];
  instr_bus_slave_t mem_d [Depth];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  logic             push_en, pop_en;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= NONE;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_bus_response_router.sv
// Gates core fetches to boot ROM / code RAM, tracks them in order and steers responses
// back; unmapped fetches are answered locally with an error one cycle after grant.
module instr_bus_response_router
  import pixel_riscv_soc_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = INSTR_BUS_MAX_OUTSTANDING,
  parameter logic [31:0] ERR_RDATA       = INSTR_BUS_ERR_RDATA
) (
  input  logic             clk,
  input  logic             rst,
  input  instr_bus_state_t instr_bus_state,
  input  logic             core_req,
  output logic             core_gnt,
  output logic             core_rvalid,
  output logic [31:0]      core_rdata,
  output logic             core_err,
  output logic             rom_req,
  input  logic             rom_gnt,
  input  logic             rom_rvalid,
  input  logic [31:0]      rom_rdata,
  output logic             ram_req,
  input  logic             ram_gnt,
  input  logic             ram_rvalid,
  input  logic [31:0]      ram_rdata,
  output logic             protocol_error
);

  instr_bus_slave_t sel;
  instr_bus_slave_t head;
  logic             full, empty;
  logic             push;
  logic             rom_expected, ram_expected;
  logic             unexpected;
  logic             protocol_error_q, protocol_error_d;
  logic             unused_state;

  assign sel          = instr_bus_state.requested_slave;
  assign unused_state = ^instr_bus_state.fetch_addr;

  // Request gating and grant return; no grant while full, even if a pop is under way.
  always_comb begin
    rom_req  = 1'b0;
    ram_req  = 1'b0;
    core_gnt = 1'b0;
    if (!full) begin
      case (sel)
        BOOT_ROM: begin
          rom_req  = core_req;
          core_gnt = rom_gnt;
        end
        CODE_RAM: begin
          ram_req  = core_req;
          core_gnt = ram_gnt;
        end
        NONE:     core_gnt = core_req;
        default:  core_gnt = 1'b0;
      endcase
    end
  end

  assign push = core_req & core_gnt;

  always_comb begin
    core_rvalid  = 1'b0;
    core_rdata   = '0;
    core_err     = 1'b0;
    rom_expected = 1'b0;
    ram_expected = 1'b0;
    if (!empty) begin
      case (head)
        BOOT_ROM: begin
          rom_expected = 1'b1;
          core_rvalid  = rom_rvalid;
          core_rdata   = rom_rvalid ? rom_rdata : '0;
        end
        CODE_RAM: begin
          ram_expected = 1'b1;
          core_rvalid  = ram_rvalid;
          core_rdata   = ram_rvalid ? ram_rdata : '0;
        end
        default: begin
          core_rvalid = 1'b1;
          core_rdata  = ERR_RDATA;
          core_err    = 1'b1;
        end
      endcase
    end
  end

  // A response from a slave not at the head is dropped and flagged until reset.
  assign unexpected       = (rom_rvalid & ~rom_expected) | (ram_rvalid & ~ram_expected);
  assign protocol_error_d = protocol_error_q | unexpected;
  assign protocol_error   = protocol_error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_error_q <= 1'b0;
    end else begin
      protocol_error_q <= protocol_error_d;
    end
  end

  instr_bus_id_fifo #(
    .Depth (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (sel),
    .pop     (core_rvalid),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_instr_bus_response_router.sv
// Directed, table-driven bench for instr_bus_response_router with MAX_OUTSTANDING=2.
module tb_instr_bus_response_router;
  import pixel_riscv_soc_pkg::*;

  localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

  logic             clk = 1'b0;
  logic             rst;
  instr_bus_state_t instr_bus_state;
  logic             core_req, core_gnt, core_rvalid, core_err;
  logic [31:0]      core_rdata;
  logic             rom_req, rom_gnt, rom_rvalid;
  logic [31:0]      rom_rdata;
  logic             ram_req, ram_gnt, ram_rvalid;
  logic [31:0]      ram_rdata;
  logic             protocol_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_bus_response_router #(
    .MAX_OUTSTANDING (2),
    .ERR_RDATA       (ErrData)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_bus_state (instr_bus_state),
    .core_req        (core_req),
    .core_gnt        (core_gnt),
    .core_rvalid     (core_rvalid),
    .core_rdata      (core_rdata),
    .core_err        (core_err),
    .rom_req         (rom_req),
    .rom_gnt         (rom_gnt),
    .rom_rvalid      (rom_rvalid),
    .rom_rdata       (rom_rdata),
    .ram_req         (ram_req),
    .ram_gnt         (ram_gnt),
    .ram_rvalid      (ram_rvalid),
    .ram_rdata       (ram_rdata),
    .protocol_error  (protocol_error)
  );

  typedef struct {
    logic             req;
    instr_bus_slave_t sel;
    logic             rg, rrv;
    logic [31:0]      rd;
    logic             mg, mrv;
    logic [31:0]      md;
    logic             e_gnt, e_rv;
    logic [31:0]      e_rd;
    logic             e_err, e_romreq, e_ramreq, e_perr;
  } vec_t;

  function automatic vec_t v(logic req, instr_bus_slave_t sel, logic rg, logic rrv,
                             logic [31:0] rd, logic mg, logic mrv, logic [31:0] md,
                             logic e_gnt, logic e_rv, logic [31:0] e_rd, logic e_err,
                             logic e_romreq, logic e_ramreq, logic e_perr);
    vec_t r;
    r.req = req; r.sel = sel; r.rg = rg; r.rrv = rrv; r.rd = rd;
    r.mg = mg; r.mrv = mrv; r.md = md;
    r.e_gnt = e_gnt; r.e_rv = e_rv; r.e_rd = e_rd; r.e_err = e_err;
    r.e_romreq = e_romreq; r.e_ramreq = e_ramreq; r.e_perr = e_perr;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check at negedge, advance to next edge.
  task automatic step(vec_t x, string tag);
    core_req                        = x.req;
    instr_bus_state.requested_slave = x.sel;
    instr_bus_state.fetch_addr      = 32'h0000_1000;
    rom_gnt = x.rg; rom_rvalid = x.rrv; rom_rdata = x.rd;
    ram_gnt = x.mg; ram_rvalid = x.mrv; ram_rdata = x.md;
    @(negedge clk);
    chk({tag, ".gnt"},     32'(core_gnt),       32'(x.e_gnt));
    chk({tag, ".rvalid"},  32'(core_rvalid),    32'(x.e_rv));
    chk({tag, ".rdata"},   core_rdata,          x.e_rd);
    chk({tag, ".err"},     32'(core_err),       32'(x.e_err));
    chk({tag, ".rom_req"}, 32'(rom_req),        32'(x.e_romreq));
    chk({tag, ".ram_req"}, 32'(ram_req),        32'(x.e_ramreq));
    chk({tag, ".perr"},    32'(protocol_error), 32'(x.e_perr));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    core_req = 1'b0; rom_gnt = 1'b0; rom_rvalid = 1'b0; rom_rdata = '0;
    ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_rdata = '0;
    instr_bus_state = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    // Reset state
    tbl.push_back(v(0, NONE,     0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 0, 0));
    // Single ROM fetch, response two cycles later
    tbl.push_back(v(1, BOOT_ROM, 1, 0, 0,            0, 0, 0,            1, 0, 0,            0, 1, 0, 0));
    tbl.push_back(v(0, NONE,     0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 0, 0));
    tbl.push_back(v(0, NONE,     0, 1, 32'h12345678, 0, 0, 0,            0, 1, 32'h12345678, 0, 0, 0, 0));
    // Unmapped fetch answered locally next cycle
    tbl.push_back(v(1, NONE,     0, 0, 0,            0, 0, 0,            1, 0, 0,            0, 0, 0, 0));
    tbl.push_back(v(0, NONE,     0, 0, 0,            0, 0, 0,            0, 1, ErrData,      1, 0, 0, 0));
    tbl.push_back(v(0, NONE,     0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 0, 0));
    // RAM data ignored when empty and no rvalid; RAM wait-state then grant
    tbl.push_back(v(0, NONE,     0, 0, 0,            0, 0, 32'hAAAA5555, 0, 0, 0,            0, 0, 0, 0));
    tbl.push_back(v(1, CODE_RAM, 0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 1, 0));
    tbl.push_back(v(1, CODE_RAM, 0, 0, 0,            1, 0, 0,            1, 0, 0,            0, 0, 1, 0));
    tbl.push_back(v(0, NONE,     0, 0, 0,            0, 1, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0));
    // Grant RAM while ROM responds
    tbl.push_back(v(1, BOOT_ROM, 1, 0, 0,            0, 0, 0,            1, 0, 0,            0, 1, 0, 0));
    tbl.push_back(v(1, CODE_RAM, 0, 1, 32'h11,       1, 0, 0,            1, 1, 32'h11,       0, 0, 1, 0));
    tbl.push_back(v(0, NONE,     0, 0, 0,            0, 1, 32'h22,       0, 1, 32'h22,       0, 0, 0, 0));
    // ROM then RAM, RAM answers first: dropped, flagged, ROM still delivered
    tbl.push_back(v(1, BOOT_ROM, 1, 0, 0,            0, 0, 0,            1, 0, 0,            0, 1, 0, 0));
    tbl.push_back(v(1, CODE_RAM, 0, 0, 0,            1, 0, 0,            1, 0, 0,            0, 0, 1, 0));
    tbl.push_back(v(1, BOOT_ROM, 1, 0, 0,            0, 1, 32'h33,       0, 0, 0,            0, 0, 0, 0));
    tbl.push_back(v(0, NONE,     0, 1, 32'h44,       0, 0, 0,            0, 1, 32'h44,       0, 0, 0, 1));
    tbl.push_back(v(0, NONE,     0, 0, 0,            0, 1, 32'h55,       0, 1, 32'h55,       0, 0, 0, 1));
    tbl.push_back(v(0, NONE,     0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 0, 1));

    do_reset();
    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Full stall, pop does not bypass; grant resumes the cycle after
    do_reset();
    step(v(1, CODE_RAM, 0, 0, 0, 1, 0, 0,      1, 0, 0,      0, 0, 1, 0), "stall.g1");
    step(v(1, CODE_RAM, 0, 0, 0, 1, 0, 0,      1, 0, 0,      0, 0, 1, 0), "stall.g2");
    step(v(1, CODE_RAM, 0, 0, 0, 1, 0, 0,      0, 0, 0,      0, 0, 0, 0), "stall.full");
    step(v(1, CODE_RAM, 0, 0, 0, 1, 1, 32'h66, 0, 1, 32'h66, 0, 0, 0, 0), "stall.pop");
    step(v(1, CODE_RAM, 0, 0, 0, 1, 0, 0,      1, 0, 0,      0, 0, 1, 0), "stall.resume");
    step(v(0, NONE,     0, 0, 0, 0, 1, 32'h67, 0, 1, 32'h67, 0, 0, 0, 0), "stall.d1");
    step(v(0, NONE,     0, 0, 0, 0, 1, 32'h68, 0, 1, 32'h68, 0, 0, 0, 0), "stall.d2");
    step(v(0, NONE,     0, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0), "stall.idle");

    // Simultaneous push/pop keeps count at 1 and moves head to ROM
    do_reset();
    step(v(1, CODE_RAM, 0, 0, 0,      1, 0, 0,      1, 0, 0,      0, 0, 1, 0), "pp.ram");
    step(v(1, BOOT_ROM, 1, 0, 0,      0, 1, 32'h77, 1, 1, 32'h77, 0, 1, 0, 0), "pp.both");
    step(v(1, BOOT_ROM, 1, 0, 0,      0, 0, 0,      1, 0, 0,      0, 1, 0, 0), "pp.fill");
    step(v(1, BOOT_ROM, 1, 0, 0,      0, 0, 0,      0, 0, 0,      0, 0, 0, 0), "pp.full");
    step(v(0, NONE,     0, 1, 32'h88, 0, 0, 0,      0, 1, 32'h88, 0, 0, 0, 0), "pp.r1");
    step(v(0, NONE,     0, 1, 32'h99, 0, 0, 0,      0, 1, 32'h99, 0, 0, 0, 0), "pp.r2");
    step(v(0, NONE,     0, 0, 0,      0, 0, 0,      0, 0, 0,      0, 0, 0, 0), "pp.idle");

    // Reset with two in flight; stray ROM rvalid is dropped and flagged
    do_reset();
    step(v(1, BOOT_ROM, 1, 0, 0,      0, 0, 0, 1, 0, 0,      0, 1, 0, 0), "rst.g1");
    step(v(1, CODE_RAM, 0, 0, 0,      1, 0, 0, 1, 0, 0,      0, 0, 1, 0), "rst.g2");
    do_reset();
    step(v(0, NONE,     0, 1, 32'hAB, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0), "rst.stray");
    step(v(1, BOOT_ROM, 1, 0, 0,      0, 0, 0, 1, 0, 0,      0, 1, 0, 1), "rst.fetch");
    step(v(0, NONE,     0, 1, 32'hCD, 0, 0, 0, 0, 1, 32'hCD, 0, 0, 0, 1), "rst.resp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
